muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/mips_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_seq.sv | 161 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: datapath width, HI/LO unit op encodings and FSM states.
package mips_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequential multiplier/divider on a {HI,LO} accumulator:
// shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step
  import mips_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  // Multiply keeps the carry out of the upper half; divide uses the borrow
  // of the trial subtraction to decide the quotient bit.
  always_comb begin
    sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    rem  = acc_i[2*WIDTH-1:WIDTH-1];
    diff = rem - {1'b0, operand_i};
    if (is_div_i) begin
      if (diff[WIDTH]) begin
        acc_o = {rem[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MIPS HI/LO unit: MULT/MULTU/DIV/DIVU in STEPS iterations on
// magnitudes, with a final sign-fix cycle, plus MTHI/MTLO writes while idle.
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int STEPS = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o
);

  localparam int CW = $clog2(STEPS + 1);
  localparam int AW = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op_q, op_d, op_in;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d, step_acc;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic             in_signed, in_div;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign op_in     = op_e'(op_i);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign abs_a     = (in_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign abs_b     = (in_signed && b_i[WIDTH-1]) ? -b_i : b_i;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .operand_i(opnd_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dz_pend_d = dz_pend_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mthi_i) hi_d = wdata_i;
        if (mtlo_i) lo_d = wdata_i;
        if (start_i) begin
          op_d    = op_in;
          neg_q_d = in_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          neg_r_d = in_signed && a_i[WIDTH-1];
          if (in_div && (b_i == '0)) begin
            dz_pend_d = 1'b1;
            state_d   = ST_FIX;
          end else begin
            dz_pend_d = 1'b0;
            cnt_d     = CW'(STEPS);
            state_d   = ST_RUN;
            // Divide shifts the dividend out of LO; multiply shifts the multiplier out.
            if (in_div) begin
              acc_d  = {{WIDTH{1'b0}}, abs_a};
              opnd_d = abs_b;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, abs_b};
              opnd_d = abs_a;
            end
          end
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!abort_i) begin
          done_d = 1'b1;
          dz_d   = dz_pend_q;
          if (!dz_pend_q) begin
            if (op_is_div(op_q)) begin
              lo_d = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
              hi_d = neg_r_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
            end else begin
              {hi_d, lo_d} = neg_q_q ? -acc_q : acc_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_pend_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      dz_pend_q <= dz_pend_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign dz_o   = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random
// operations compared against an arithmetic HI/LO reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        abort_i = 1'b0;
  logic        mthi_i = 1'b0;
  logic        mtlo_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o, dz_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] refHi = '0;
  logic [31:0] refLo = '0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_seq #(.WIDTH(32), .STEPS(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .op_i   (op_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .abort_i(abort_i),
    .mthi_i (mthi_i),
    .mtlo_i (mtlo_i),
    .wdata_i(wdata_i),
    .hi_o   (hi_o),
    .lo_o   (lo_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .dz_o   (dz_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Architectural result of one operation, from plain 64-bit arithmetic.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] prevHi, input logic [31:0] prevLo,
                                   output logic [31:0] eHi, output logic [31:0] eLo, output bit eDz);
    longint sa, sb, q, r;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    eDz = 1'b0;
    eHi = prevHi;
    eLo = prevLo;
    case (op)
      MULT: begin
        p = 64'(sa * sb);
        eHi = p[63:32];
        eLo = p[31:0];
      end
      MULTU: begin
        p = ua * ub;
        eHi = p[63:32];
        eLo = p[31:0];
      end
      DIV: begin
        if (b == 0) eDz = 1'b1;
        else begin
          q = sa / sb;
          r = sa % sb;
          eLo = q[31:0];
          eHi = r[31:0];
        end
      end
      default: begin
        if (b == 0) eDz = 1'b1;
        else begin
          p = ua / ub;
          eLo = p[31:0];
          p = ua % ub;
          eHi = p[31:0];
        end
      end
    endcase
  endfunction

  task automatic mtWrite(input bit hiEn, input bit loEn, input logic [31:0] data);
    @(negedge clk);
    mthi_i = hiEn;
    mtlo_i = loEn;
    wdata_i = data;
    @(negedge clk);
    mthi_i = 1'b0;
    mtlo_i = 1'b0;
    if (hiEn) refHi = data;
    if (loEn) refLo = data;
    checkOutput("mt_hi", 64'(hi_o), 64'(refHi));
    checkOutput("mt_lo", 64'(lo_o), 64'(refLo));
  endtask

  // Runs one operation; glitch fires an ignored start plus MTHI/MTLO at edge 5,
  // coMt issues an MTHI on the same cycle as start.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit glitch, input bit coMt);
    logic [31:0] eHi, eLo, mtData;
    bit eDz;
    int lat;
    mtData = $urandom;
    if (coMt) refHi = mtData;
    refModel(op, a, b, refHi, refLo, eHi, eLo, eDz);
    @(negedge clk);
    op_i = op;
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    mthi_i = coMt;
    wdata_i = mtData;
    @(negedge clk);
    start_i = 1'b0;
    mthi_i = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    op_i = 2'($urandom);
    checkOutput("busy_after_start", 64'(busy_o), 64'(1));
    if (coMt) checkOutput("mthi_with_start", 64'(hi_o), 64'(mtData));
    lat = 0;
    while (!done_o && lat < 60) begin
      if (glitch && lat == 4) begin
        start_i = 1'b1;
        op_i = DIVU;
        b_i = '0;
        mthi_i = 1'b1;
        mtlo_i = 1'b1;
        wdata_i = $urandom;
      end else begin
        start_i = 1'b0;
        mthi_i = 1'b0;
        mtlo_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start_i = 1'b0;
    mthi_i = 1'b0;
    mtlo_i = 1'b0;
    checkOutput("done_latency", 64'(lat), eDz ? 64'(1) : 64'(33));
    checkOutput("result_hi", 64'(hi_o), 64'(eHi));
    checkOutput("result_lo", 64'(lo_o), 64'(eLo));
    checkOutput("dz_flag", 64'(dz_o), 64'(eDz));
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done_o), 64'(0));
    checkOutput("dz_one_cycle", 64'(dz_o), 64'(0));
    checkOutput("busy_back_idle", 64'(busy_o), 64'(0));
    refHi = eHi;
    refLo = eLo;
  endtask

  // Starts an operation and raises abort after edge abortAt (sampled one edge later).
  task automatic abortOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int abortAt);
    int lat;
    bit sawDone;
    @(negedge clk);
    op_i = op;
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat = 0;
    sawDone = 1'b0;
    while (lat < abortAt) begin
      @(negedge clk);
      lat++;
      if (done_o) sawDone = 1'b1;
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checkOutput("abort_busy_low", 64'(busy_o), 64'(0));
    if (done_o || dz_o) sawDone = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done_o) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", 64'(sawDone), 64'(0));
    checkOutput("abort_hi_kept", 64'(hi_o), 64'(refHi));
    checkOutput("abort_lo_kept", 64'(lo_o), 64'(refLo));
  endtask

  task automatic resetMidOp();
    @(negedge clk);
    op_i = MULTU;
    a_i = 32'h1234_5678;
    b_i = 32'h9abc_def0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_hi_zero", 64'(hi_o), 64'(0));
    checkOutput("rst_lo_zero", 64'(lo_o), 64'(0));
    checkOutput("rst_busy_zero", 64'(busy_o), 64'(0));
    checkOutput("rst_done_zero", 64'(done_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    refHi = '0;
    refLo = '0;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      3: return 32'(-$signed(32'($urandom_range(1, 20))));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb;
    #12;
    checkOutput("reset_hi", 64'(hi_o), 64'(0));
    checkOutput("reset_lo", 64'(lo_o), 64'(0));
    checkOutput("reset_busy", 64'(busy_o), 64'(0));
    checkOutput("reset_done", 64'(done_o), 64'(0));
    checkOutput("reset_dz", 64'(dz_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    mtWrite(1'b1, 1'b1, 32'hDEAD_BEEF);
    applyStimulus(MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    checkOutput("mult_neg3x5_hi", 64'(hi_o), 64'(32'hFFFF_FFFF));
    checkOutput("mult_neg3x5_lo", 64'(lo_o), 64'(32'hFFFF_FFF1));
    applyStimulus(DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    checkOutput("divu_100_7_lo", 64'(lo_o), 64'(14));
    checkOutput("divu_100_7_hi", 64'(hi_o), 64'(2));
    applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    checkOutput("div_m7_2_lo", 64'(lo_o), 64'(32'hFFFF_FFFD));
    checkOutput("div_m7_2_hi", 64'(hi_o), 64'(32'hFFFF_FFFF));
    mtWrite(1'b1, 1'b0, 32'h0000_1234);
    applyStimulus(DIV, 32'd55, 32'd0, 1'b0, 1'b0);
    checkOutput("dz_hi_kept", 64'(hi_o), 64'(32'h1234));
    applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("div_ovf_lo", 64'(lo_o), 64'(32'h8000_0000));
    checkOutput("div_ovf_hi", 64'(hi_o), 64'(0));
    applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    checkOutput("multu_max_hi", 64'(hi_o), 64'(32'hFFFF_FFFE));
    checkOutput("multu_max_lo", 64'(lo_o), 64'(1));
    abortOp(MULT, 32'd1234, 32'd5678, 10);
    abortOp(DIVU, 32'd999, 32'd3, 32);
    abortOp(DIV, 32'd5, 32'd0, 0);
    resetMidOp();
    applyStimulus(MULT, 32'd6, 32'd7, 1'b0, 1'b0);
    checkOutput("mult_6x7_lo", 64'(lo_o), 64'(42));
    applyStimulus(DIVU, 32'd77, 32'd0, 1'b0, 1'b1);
    applyStimulus(MULT, 32'hFFFF_FF00, 32'h0000_0100, 1'b0, 1'b1);

    repeat (30) begin
      ra = pickOperand();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pickOperand();
      applyStimulus(2'($urandom_range(0, 3)), ra, rb, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
